// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if -- bundles every non-clock signal of the fetch stage.
//
// Signal groups
//   Instruction memory : mem_req, mem_addr (fetch -> memory)
//                        mem_gnt, mem_rvalid, mem_rdata (memory -> fetch)
//   Redirect           : redirect, redirect_pc (core -> fetch)
//   Instruction port   : inst_valid, inst_data, inst_pc (fetch -> core)
//                        inst_ready (core -> fetch)
//
// Handshake semantics (all of them, in one place):
//   * Memory request: a request is accepted only in a cycle where
//     mem_req && mem_gnt. A request that is not granted is non-binding;
//     the fetch stage may drop or change it next cycle.
//   * Memory response: mem_rvalid is a one-cycle qualifier for mem_rdata.
//     Responses come back in request order and there is no back-pressure
//     on them.
//   * Instruction port: strict valid/ready. The head entry is transferred
//     in a cycle where inst_valid && inst_ready. inst_valid, inst_data and
//     inst_pc never depend on inst_ready in the same cycle.
//
// Modports
//   master : the fetch stage (ifetch_queue)
//   slave  : the environment (memory + core, or a testbench)

interface ifetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction-fetch stage with a prefetch queue.
//
// Issues word reads to a multi-cycle instruction memory and buffers the
// returned instructions, tagged with their addresses, in a small FIFO that
// the core drains through a valid/ready port. A redirect from the core
// flushes the FIFO, restarts fetch at redirect_pc and arranges for every
// response still in flight to be thrown away.
//
// Parameters
//   ADDR_W   : word-address width (width of every PC value)
//   DATA_W   : instruction width
//   DEPTH    : FIFO entries, and the cap on entries + outstanding requests
//              (power of two, >= 2)
//   RESET_PC : first fetch address after reset
//
// Ports
//   Clock : single clock, all state updates on the rising edge
//   Reset : synchronous, active-high
//   bus   : ifetch_queue_if.master (memory, redirect and instruction ports)
//
// Credit scheme: a request is only raised while count + outstanding < DEPTH,
// so every response that is kept is guaranteed a free FIFO slot. That is why
// the push path needs no full check.

module ifetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            Clock,
  input logic            Reset,
  ifetch_queue_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  cnt_t              outstanding;
  cnt_t              discard;
  cnt_t              count;
  ptr_t              rd_ptr;
  ptr_t              wr_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  // Next-state values
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] resp_pc_nxt;
  cnt_t              outstanding_nxt;
  cnt_t              discard_nxt;
  cnt_t              count_nxt;
  ptr_t              rd_ptr_nxt;
  ptr_t              wr_ptr_nxt;

  // Per-cycle events
  logic [CW:0] credit_used;
  logic        credit_ok;
  logic        req;
  logic        grant;
  logic        rsp_take;
  logic        push;
  logic        pop;

  // ------------------------------------------------------------------
  // Request / event decode
  // ------------------------------------------------------------------
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok   = credit_used < {1'b0, DEPTH_C};

  // Holding mem_req low during a redirect keeps grant at zero in that
  // cycle, so the discard count only has to account for responses.
  assign req   = !Reset && !bus.redirect && credit_ok;
  assign grant = req && bus.mem_gnt;

  // A response with nothing outstanding is a protocol error: ignore it
  // completely so that late responses after a reset cannot corrupt state.
  assign rsp_take = bus.mem_rvalid && (outstanding != '0);

  // Kept responses go into the FIFO; stale ones (discard > 0) and any
  // response arriving in a redirect cycle are dropped.
  assign push = rsp_take && (discard == '0) && !bus.redirect;

  // The core's pop is ignored in a redirect cycle; the flush wins.
  assign pop = (count != '0) && bus.inst_ready && !bus.redirect;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    outstanding_nxt = outstanding + cnt_t'(grant) - cnt_t'(rsp_take);
    discard_nxt     = discard;
    count_nxt       = count;
    rd_ptr_nxt      = rd_ptr;
    wr_ptr_nxt      = wr_ptr;

    if (bus.redirect) begin
      // Every request still in flight after this edge belongs to the old
      // path, so all of them must be discarded when they return.
      fetch_pc_nxt = bus.redirect_pc;
      resp_pc_nxt  = bus.redirect_pc;
      discard_nxt  = outstanding_nxt;
      count_nxt    = '0;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
    end else begin
      fetch_pc_nxt = fetch_pc + ADDR_W'(grant);
      resp_pc_nxt  = resp_pc + ADDR_W'(push);
      if (rsp_take && (discard != '0)) begin
        discard_nxt = discard - cnt_t'(1);
      end
      count_nxt  = count + cnt_t'(push) - cnt_t'(pop);
      rd_ptr_nxt = rd_ptr + ptr_t'(pop);
      wr_ptr_nxt = wr_ptr + ptr_t'(push);
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      // Storage is cleared so the head outputs read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      count       <= count_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      if (push) begin
        data_mem[wr_ptr] <= bus.mem_rdata;
        pc_mem[wr_ptr]   <= resp_pc;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs: all from registered state (mem_req also sees Reset and
  // redirect). No path from mem_gnt, mem_rvalid or inst_ready.
  // ------------------------------------------------------------------
  assign bus.mem_req    = req;
  assign bus.mem_addr   = fetch_pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = data_mem[rd_ptr];
  assign bus.inst_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue -- self-checking bench for ifetch_queue.
//
// A request-level memory model answers grants after a programmable latency
// with data = address ^ 0xA5A5. A behavioural model tracks requests in
// flight (tagged stale on redirect) and the expected instruction queue; a
// compare process checks the DUT against it every cycle. Directed phases add
// hand-computed literal expectations. A second instance with
// RESET_PC=0xFFFE checks address wrap.

module tb_ifetch_queue;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ifetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus_w ();

  ifetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  ifetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut_w (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_w)
  );

  // ---------------- counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- memory model (main DUT) ----------------
  logic            gnt_allow = 1'b0;
  int              lat = 1;
  int              cyc = 0;
  logic [AW-1:0]   pend_addr[$];
  int              pend_due[$];

  assign bus.mem_gnt = gnt_allow;

  always @(posedge clk) begin
    if (bus.mem_rvalid === 1'b1) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
      pend_addr.push_back(bus.mem_addr);
      pend_due.push_back(cyc + lat);
    end
    cyc <= cyc + 1;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc + 1) begin
      bus.mem_rvalid <= 1'b1;
      bus.mem_rdata  <= pend_addr[0] ^ 16'hA5A5;
    end else begin
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
    end
  end

  // ---------------- zero-wait memory (wrap instance) ----------------
  assign bus_w.mem_gnt     = 1'b1;
  assign bus_w.redirect    = 1'b0;
  assign bus_w.redirect_pc = '0;
  assign bus_w.inst_ready  = 1'b1;

  always @(posedge clk) begin
    bus_w.mem_rvalid <= bus_w.mem_req;
    bus_w.mem_rdata  <= bus_w.mem_addr ^ 16'hA5A5;
  end

  // ---------------- behavioural model / scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];      // {pc, data} expected at the head, in order
  logic [AW-1:0]    fl_addr[$];    // requests in flight, oldest first
  bit               fl_stale[$];   // in-flight request belongs to a flushed path
  logic [AW-1:0]    m_fetch_pc = '0;
  bit               check_en = 1'b0;

  function automatic bit model_req();
    return !rst && !bus.redirect && ((exp_q.size() + fl_addr.size()) < DEPTH);
  endfunction

  task automatic model_step();
    bit            grant, rsp, pop, stale;
    logic [AW-1:0] a;
    if (rst) begin
      exp_q.delete();
      fl_addr.delete();
      fl_stale.delete();
      m_fetch_pc = 16'h0000;
      check_en   = 1'b1;
      return;
    end
    grant = model_req() && (bus.mem_gnt === 1'b1);
    rsp   = (bus.mem_rvalid === 1'b1) && (fl_addr.size() > 0);
    pop   = (exp_q.size() > 0) && (bus.inst_ready === 1'b1);
    if (bus.redirect) begin
      if (rsp) begin
        fl_addr.delete(0);
        fl_stale.delete(0);
      end
      foreach (fl_stale[i]) fl_stale[i] = 1'b1;
      exp_q.delete();
      m_fetch_pc = bus.redirect_pc;
    end else begin
      if (pop) exp_q.delete(0);
      if (rsp) begin
        a     = fl_addr.pop_front();
        stale = fl_stale.pop_front();
        if (!stale) exp_q.push_back({a, bus.mem_rdata});
      end
      if (grant) begin
        fl_addr.push_back(m_fetch_pc);
        fl_stale.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 16'd1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("mem_req", bus.mem_req, model_req());
      chk("mem_addr", bus.mem_addr, m_fetch_pc);
      chk("inst_valid", bus.inst_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("inst_pc", bus.inst_pc, exp_q[0][AW+DW-1:DW]);
        chk("inst_data", bus.inst_data, exp_q[0][DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    gnt_allow      = 1'b0;
    bus.inst_ready = 1'b1;
    bus.redirect   = 1'b0;
    do begin
      tick();
      n++;
    end while ((pend_addr.size() + exp_q.size() + fl_addr.size()) != 0 && n < 40);
    chk("drain_empty", pend_addr.size() + exp_q.size() + fl_addr.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      tick();
      @(negedge clk);
      n++;
    end while (bus.inst_valid !== 1'b1 && n < budget);
    chk(name, bus.inst_valid, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [AW-1:0] w_pc_exp[4];
  logic [DW-1:0] w_data_exp[4];

  initial begin
    w_pc_exp   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    w_data_exp = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;
    gnt_allow       = 1'b1;
    lat             = 1;
    rst             = 1'b1;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_data", bus.inst_data, 16'h0000);
    chk("rst_inst_pc", bus.inst_pc, 16'h0000);
    chk("rst_w_mem_addr", bus_w.mem_addr, 16'hFFFE);

    // Phase 1: zero-wait streaming, first valid two cycles after the
    // first Reset=0 cycle, then one instruction per cycle.
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("p1_first_req", bus.mem_req, 1'b1);
    chk("p1_valid_c0", bus.inst_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("p1_valid_c1", bus.inst_valid, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      @(negedge clk);
      chk("p1_valid", bus.inst_valid, 1'b1);
      chk("p1_pc", bus.inst_pc, k);
      chk("p1_data", bus.inst_data, 16'(k) ^ 16'hA5A5);
      if (k < 4) begin
        chk("w_valid", bus_w.inst_valid, 1'b1);
        chk("w_pc", bus_w.inst_pc, w_pc_exp[k]);
        chk("w_data", bus_w.inst_data, w_data_exp[k]);
      end
    end

    // Phase 2: back-pressure for 20 cycles, queue fills, requests stop.
    tick();
    bus.inst_ready = 1'b0;
    repeat (19) tick();
    @(negedge clk);
    chk("p2_full_valid", bus.inst_valid, 1'b1);
    chk("p2_full_head", bus.inst_pc, 16'h0007);
    chk("p2_req_off", bus.mem_req, 1'b0);
    chk("p2_fetch_addr", bus.mem_addr, 16'h000B);
    tick();
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("p2_resume_valid", bus.inst_valid, 1'b1);
      chk("p2_resume_pc", bus.inst_pc, 7 + k);
      tick();
    end

    // Phase 3: latency 3, two outstanding, redirect to 0x0030.
    drain();
    lat       = 3;
    gnt_allow = 1'b1;
    tick();
    tick();
    gnt_allow       = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0030;
    @(negedge clk);
    chk("p3_req_in_redirect", bus.mem_req, 1'b0);
    tick();
    bus.redirect = 1'b0;
    gnt_allow    = 1'b1;
    @(negedge clk);
    chk("p3_valid_t1", bus.inst_valid, 1'b0);
    chk("p3_req_t1", bus.mem_req, 1'b1);
    chk("p3_addr_t1", bus.mem_addr, 16'h0030);
    wait_valid("p3_wait_valid", 12);
    chk("p3_pc", bus.inst_pc, 16'h0030);
    chk("p3_data", bus.inst_data, 16'hA595);

    // Phase 4: redirect together with a response and a pop
    // (three entries queued, one outstanding whose data arrives now).
    drain();
    lat            = 3;
    bus.inst_ready = 1'b0;
    gnt_allow      = 1'b1;
    repeat (6) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    bus.inst_ready  = 1'b1;
    @(negedge clk);
    chk("p4_valid_before_flush", bus.inst_valid, 1'b1);
    chk("p4_req_in_redirect", bus.mem_req, 1'b0);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("p4_flushed", bus.inst_valid, 1'b0);
    chk("p4_req_t1", bus.mem_req, 1'b1);
    chk("p4_addr_t1", bus.mem_addr, 16'h0100);
    wait_valid("p4_wait_valid", 12);
    chk("p4_pc", bus.inst_pc, 16'h0100);
    chk("p4_data", bus.inst_data, 16'hA4A5);
    tick();
    @(negedge clk);
    chk("p4_pc_next", bus.inst_pc, 16'h0101);
    chk("p4_data_next", bus.inst_data, 16'hA4A4);

    // Phase 5: reset pulse with three requests outstanding.
    drain();
    lat       = 3;
    gnt_allow = 1'b1;
    repeat (3) tick();
    rst       = 1'b1;
    gnt_allow = 1'b0;
    @(negedge clk);
    chk("p5_req_in_reset", bus.mem_req, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("p5_req", bus.mem_req, 1'b1);
    chk("p5_addr", bus.mem_addr, 16'h0000);
    chk("p5_valid", bus.inst_valid, 1'b0);
    chk("p5_pc", bus.inst_pc, 16'h0000);
    chk("p5_data", bus.inst_data, 16'h0000);
    tick();
    @(negedge clk);
    chk("p5_late_rsp_ignored", bus.inst_valid, 1'b0);
    tick();
    lat       = 1;
    gnt_allow = 1'b1;
    wait_valid("p5_wait_valid", 10);
    chk("p5_restart_pc", bus.inst_pc, 16'h0000);
    chk("p5_restart_data", bus.inst_data, 16'hA5A5);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
